cellrv32_bus_initiator: RTL and testbench
=========================================

Name: cellrv32_bus_initiator

Overview:
- Single-outstanding initiator for the processor-internal peripheral bus: the other end of the strobe/ack protocol that IO responders such as the GPIO port implement.
- Accepts word read/write requests from a client (debug module, boot sequencer, test DMA) over a valid/ready handshake.
- Issues one-cycle rden/wren strobes, waits for ack with a bounded timeout, and returns read data and an error flag over a valid/ready response channel.

Parameters:
TMO_CYCLES, 16, max cycles waited for bus_ack_i after the strobe before error (range 2..255)

Ports:
clk_i  in  1  global clock
rst_i  in  1  global reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready at rising edge
req_we_i  in  1  1=write, 0=read
req_op_i  in  2  00 plain, 01 bit-set, 10 bit-clear, 11 toggle (meaningful only with RMW macro)
req_addr_i  in  32  byte address; bits [1:0] ignored
req_wdata_i  in  32  write data / bit mask
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready at rising edge
rsp_rdata_o  out  32  read data (old value for RMW)
rsp_err_o  out  1  timeout occurred
bus_addr_o  out  32  bus address, word aligned
bus_rden_o  out  1  read strobe
bus_wren_o  out  1  write strobe
bus_data_o  out  32  write data
bus_data_i  in  32  OR-ed responder read data
bus_ack_i  in  1  responder acknowledge

Behaviour:
- Reset: FSM=IDLE; req_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0; bus strobes=0, bus_addr_o=0, bus_data_o=0; timeout counter=0. Reset mid-transfer drops strobes immediately (async). The transfer is lost; no response is issued.
- FSM states: IDLE, ACCESS, WAIT, MODIFY (macro only), RESP.
- IDLE:
  - req_ready_o=1.
  - On handshake: register we/op/addr/wdata, drive bus_addr_o={addr[31:2],2'b00}, go to ACCESS.
  - Exactly one of bus_rden_o/bus_wren_o is set (registered) for the ACCESS cycle only.
- ACCESS:
  - Strobe high for one cycle. bus_data_o=wdata during a write strobe and 0 otherwise.
  - Go to WAIT, counter cleared.
  - bus_ack_i asserted in ACCESS is also honoured, so zero-latency responders work.
- WAIT:
  - Strobes low, bus_addr_o held, counter increments each cycle.
  - bus_ack_i=1: capture bus_data_i if read, otherwise 0. Go to RESP with err=0.
  - Counter reaches TMO_CYCLES-1 without ack: go to RESP with err=1, rdata=0.
  - Ack on the same cycle as the terminal count: ack wins, err=0.
- RESP:
  - rsp_valid_o=1, outputs stable until rsp_ready_i. Then go to IDLE.
  - req_ready_o=0 in every state except IDLE.
- Latency, registered responder (ack one cycle after strobe): accept edge E0; strobe high E0..E1; ack sampled at E2; rsp_valid_o high from E2. Best-case throughput is one transfer per 4 cycles.
- Spurious bus_ack_i in IDLE or RESP is ignored.
- rsp_ready_i held high: response lasts exactly 1 cycle.
- A write responds with rdata=0, err per ack.
- A late ack arriving after a timeout is ignored.

Optional Feature:
- Macro: CELLRV32_BUS_INIT_RMW_EN.
- Defined:
  - req_we_i=1 with req_op_i≠00 performs an atomic read-modify-write: ACCESS(read) → WAIT → MODIFY → ACCESS(write) → WAIT → RESP.
  - MODIFY computes in one cycle: new = old|mask (01), old&~mask (10), or old^mask (11).
  - rsp_rdata_o returns the old value.
  - A read-phase timeout skips the write and responds err=1.
  - A write-phase timeout responds err=1 with the old value.
  - No other request is accepted during the sequence.
- Undefined: req_op_i ignored, MODIFY state absent, all writes plain.

Decomposition:
- Shared package cellrv32_package:
  - bus_init_op_t enum (OP_PLAIN/OP_SET/OP_CLR/OP_TGL).
  - bus_init_state_t enum.
  - Request struct {we, op, addr, wdata}.
- No sub-module: single FSM plus counter. The MODIFY ALU is a small function in the package.

Test Plan:
1. Read GPIO input-low word with gpio_i[31:0]=32'hA5A5_0F0F and a registered-ack responder → bus_rden_o is high 1 cycle, rsp_valid_o 2 edges after accept, rsp_rdata_o=32'hA5A5_0F0F, err=0.
2. Write 32'h0000_00FF to output-low, then read it back → bus_wren_o 1 cycle with bus_data_o=32'h0000_00FF; readback=32'h0000_00FF; gpio_o[7:0]=8'hFF.
3. Read unmapped address with no ack, TMO_CYCLES=16 → rsp_err_o=1, rdata=0, response 16 cycles after the strobe cycle; a late ack injected afterwards has no effect.
4. rsp_ready_i held low for 5 cycles while req_valid_i=1 → rsp outputs stable for all 5 cycles, req_ready_o=0 throughout, next request accepted only after the response handshake.
5. rst_i asserted in WAIT → strobes/rsp_valid_o go 0 without a clock edge; after release req_ready_o=1 and no response is emitted.
6. (RMW_EN) output-low=32'h0000_00F0, bit-set mask 32'h0000_000F → read then write strobe, bus_data_o=32'h0000_00FF, rsp_rdata_o=32'h0000_00F0; bit-clear with mask 32'h0000_0030 yields 32'h0000_00CF.

Source files
------------

// File: rtl/cellrv32_bus_initiator_pkg.sv
// Shared types for the peripheral-bus initiator: request record, op codes, FSM states, RMW ALU.
// Optional read-modify-write support is enabled by defining CELLRV32_BUS_INIT_RMW_EN.
package cellrv32_package;

    typedef enum logic [1:0] {
        OP_PLAIN = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_TGL   = 2'b11
    } bus_init_op_t;

`ifdef CELLRV32_BUS_INIT_RMW_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_MODIFY = 3'd4
    } bus_init_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } bus_init_state_t;
`endif

    typedef struct packed {
        logic         we;
        bus_init_op_t op;
        logic [31:0]  addr;
        logic [31:0]  wdata;
    } bus_init_req_t;

    localparam int unsigned BUS_INIT_CNT_W = 8;

    function automatic logic [31:0] bus_init_modify(input bus_init_op_t op,
                                                    input logic [31:0] old_val,
                                                    input logic [31:0] mask);
        logic [31:0] new_val;
        case (op)
            OP_SET:  new_val = old_val | mask;
            OP_CLR:  new_val = old_val & ~mask;
            OP_TGL:  new_val = old_val ^ mask;
            default: new_val = old_val;
        endcase
        return new_val;
    endfunction

endpackage

// File: rtl/cellrv32_bus_initiator.sv
// Single-outstanding strobe/ack initiator with bounded ack timeout and valid/ready client ports.
// Define CELLRV32_BUS_INIT_RMW_EN to add atomic bit-set/clear/toggle read-modify-write.
module cellrv32_bus_initiator
    import cellrv32_package::*;
#(
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] bus_addr_o,
    output logic        bus_rden_o,
    output logic        bus_wren_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    localparam logic [BUS_INIT_CNT_W-1:0] TMO_LAST = BUS_INIT_CNT_W'(TMO_CYCLES - 1);

    bus_init_state_t           state_r;
    bus_init_req_t             req_r;
    logic [BUS_INIT_CNT_W-1:0] cnt_r;
    logic [31:0]               old_r;
    logic                      wr_phase_r;
    logic                      req_ready_r;
    logic                      rsp_valid_r;
    logic                      rsp_err_r;
    logic [31:0]               rsp_rdata_r;
    logic                      bus_rden_r;
    logic                      bus_wren_r;
    logic [31:0]               bus_data_r;

    bus_init_req_t             req_s;
    logic                      rmw_s;
    logic                      rmw_req_s;
    logic                      rd_first_s;
    logic [31:0]               rsp_ok_data_s;
    logic [31:0]               rsp_tmo_data_s;
    logic                      unused_s;

`ifdef CELLRV32_BUS_INIT_RMW_EN
    assign req_s     = '{we: req_we_i, op: bus_init_op_t'(req_op_i),
                         addr: {req_addr_i[31:2], 2'b00}, wdata: req_wdata_i};
    assign rmw_s     = req_r.we & (req_r.op != OP_PLAIN);
    assign rmw_req_s = req_we_i & (req_op_i != 2'b00);
    assign unused_s  = ^req_addr_i[1:0];
`else
    assign req_s     = '{we: req_we_i, op: OP_PLAIN,
                         addr: {req_addr_i[31:2], 2'b00}, wdata: req_wdata_i};
    assign rmw_s     = 1'b0;
    assign rmw_req_s = 1'b0;
    assign unused_s  = ^{req_addr_i[1:0], req_op_i, req_r.op};
`endif

    // An RMW always starts with a read strobe; its write strobe follows from MODIFY.
    assign rd_first_s     = ~req_we_i | rmw_req_s;
    assign rsp_ok_data_s  = rmw_s ? old_r : (req_r.we ? 32'h0000_0000 : bus_data_i);
    assign rsp_tmo_data_s = (rmw_s & wr_phase_r) ? old_r : 32'h0000_0000;

    // Transfer FSM: owns every output register and the ack timeout counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            req_r       <= '0;
            cnt_r       <= '0;
            old_r       <= 32'h0000_0000;
            wr_phase_r  <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            bus_rden_r  <= 1'b0;
            bus_wren_r  <= 1'b0;
            bus_data_r  <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_r       <= req_s;
                        cnt_r       <= '0;
                        wr_phase_r  <= ~rd_first_s;
                        bus_rden_r  <= rd_first_s;
                        bus_wren_r  <= ~rd_first_s;
                        bus_data_r  <= rd_first_s ? 32'h0000_0000 : req_wdata_i;
                        req_ready_r <= 1'b0;
                        state_r     <= ST_ACCESS;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end

                // ACCESS shares the ack path so a same-cycle ack is not lost.
                ST_ACCESS, ST_WAIT: begin
                    bus_rden_r <= 1'b0;
                    bus_wren_r <= 1'b0;
                    bus_data_r <= 32'h0000_0000;
                    if (bus_ack_i) begin
                        cnt_r <= '0;
                        if (rmw_s && !wr_phase_r) begin
                            old_r <= bus_data_i;
`ifdef CELLRV32_BUS_INIT_RMW_EN
                            state_r <= ST_MODIFY;
`else
                            state_r <= ST_IDLE;
`endif
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_rdata_r <= rsp_ok_data_s;
                            state_r     <= ST_RESP;
                        end
                    end else if (state_r == ST_ACCESS) begin
                        cnt_r   <= '0;
                        state_r <= ST_WAIT;
                    end else if (cnt_r == TMO_LAST) begin
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= rsp_tmo_data_s;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end

`ifdef CELLRV32_BUS_INIT_RMW_EN
                ST_MODIFY: begin
                    bus_wren_r <= 1'b1;
                    bus_data_r <= bus_init_modify(req_r.op, old_r, req_r.wdata);
                    wr_phase_r <= 1'b1;
                    state_r    <= ST_ACCESS;
                end
`endif

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end

                default: begin
                    bus_rden_r  <= 1'b0;
                    bus_wren_r  <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign bus_addr_o  = req_r.addr;
    assign bus_rden_o  = bus_rden_r;
    assign bus_wren_o  = bus_wren_r;
    assign bus_data_o  = bus_data_r;

endmodule

// File: tb/tb_cellrv32_bus_initiator.sv
// Self-checking bench: table vectors, directed corner sequences and a randomized run
// against a memory-level reference model. RMW rows are compiled with CELLRV32_BUS_INIT_RMW_EN.
module tb_cellrv32_bus_initiator;

    localparam int TMO = 16;
    localparam logic [31:0] GPIO_IN = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] bus_addr, bus_dout, bus_din;
    logic        bus_rden, bus_wren, bus_ack;

    cellrv32_bus_initiator #(.TMO_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .bus_addr_o(bus_addr), .bus_rden_o(bus_rden),
        .bus_wren_o(bus_wren), .bus_data_o(bus_dout), .bus_data_i(bus_din),
        .bus_ack_i(bus_ack)
    );

    always #5 clk = ~clk;

    // Responder: word 0 = GPIO input (read-only), word 2 = GPIO output, >= 0x10 unmapped.
    // Latency 0 acks in the strobe cycle; latency L acks L cycles after the strobe.
    logic [31:0] dev_mem [4] = '{default: 32'h0};
    int          lat_rd, lat_wr, cd = 0, cur_lat;
    logic [31:0] hold_d = 32'h0, dev_rd;
    logic        spur_ack, strobe_ok;

    assign strobe_ok = (bus_rden | bus_wren) && (bus_addr[31:4] == 28'h0);
    assign cur_lat   = bus_rden ? lat_rd : lat_wr;
    assign dev_rd    = (bus_addr[3:2] == 2'd0) ? GPIO_IN : dev_mem[bus_addr[3:2]];
    assign bus_ack   = spur_ack || (strobe_ok && cur_lat == 0) || (cd == 1);
    assign bus_din   = (strobe_ok && cur_lat == 0 && bus_rden) ? dev_rd :
                       ((cd == 1) ? hold_d : 32'h0);

    always @(posedge clk) begin
        if (strobe_ok && cur_lat >= 1) begin
            cd     <= cur_lat;
            hold_d <= bus_rden ? dev_rd : 32'hDEAD_BEEF;
        end else if (cd > 0) begin
            cd <= cd - 1;
        end
        if (strobe_ok && bus_wren && bus_addr[3:2] != 2'd0)
            dev_mem[bus_addr[3:2]] <= bus_dout;
    end

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic is_rmw(input logic we, input logic [1:0] op);
`ifdef CELLRV32_BUS_INIT_RMW_EN
        return we && (op != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  op;
        logic [31:0] addr, wdata;
        int          lrd, lwr;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_edges;
        logic [31:0] exp_wd;   // data of the last write strobe, 0 if none
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input int lrd, input int lwr,
                                input logic [31:0] erd, input logic eerr, input int eedg,
                                input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.op = op; v.addr = addr; v.wdata = wd; v.lrd = lrd; v.lwr = lwr;
        v.exp_rd = erd; v.exp_err = eerr; v.exp_edges = eedg; v.exp_wd = ewd;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int n, g;
        logic done, first_rd;
        logic [31:0] wd_seen;
        first_rd = !v.we || is_rmw(v.we, v.op);
        lat_rd = v.lrd;
        lat_wr = v.lwr;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_op = v.op;
        req_addr = v.addr; req_wdata = v.wdata; rsp_ready = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        chk({tag, ".accept"}, 32'(g < 50), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".rden"}, 32'(bus_rden), 32'(first_rd));
        chk({tag, ".wren"}, 32'(bus_wren), 32'(!first_rd));
        chk({tag, ".addr"}, bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, ".sdata"}, bus_dout, first_rd ? 32'h0 : v.wdata);
        chk({tag, ".busy"}, 32'(req_ready), 32'd0);
        wd_seen = bus_wren ? bus_dout : 32'h0;
        n = 0; done = 1'b0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (bus_wren) wd_seen = bus_dout;
            if (rsp_valid) done = 1'b1;
        end
        chk({tag, ".edges"}, 32'(n), 32'(v.exp_edges));
        chk({tag, ".rdata"}, rsp_rdata, v.exp_rd);
        chk({tag, ".err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({tag, ".wdata"}, wd_seen, v.exp_wd);
        @(posedge clk); #1;
        chk({tag, ".rsp1cyc"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        g = 0;
        while (cd != 0 && g < 100) begin @(posedge clk); g++; end
    endtask

    vec_t        vecs[$];
    vec_t        rv;
    logic [31:0] model_mem [4];
    logic [31:0] old_v, new_v;
    logic [2:0]  idx;
    int          n, seen, lat, pool[6];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 2'b00;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        lat_rd = 1; lat_wr = 1; spur_ack = 1'b0;
        pool = '{0, 1, 2, 3, 16, 17};

        vecs.push_back(mk(1, 0, 32'h08, 32'h0000_00FF, 1, 1, 32'h0, 0, 2, 32'h0000_00FF));
        vecs.push_back(mk(0, 0, 32'h08, 32'h0, 1, 1, 32'h0000_00FF, 0, 2, 32'h0));
        vecs.push_back(mk(0, 0, 32'h00, 32'h0, 1, 1, GPIO_IN, 0, 2, 32'h0));
        vecs.push_back(mk(1, 0, 32'h04, 32'h1234_5678, 0, 0, 32'h0, 0, 1, 32'h1234_5678));
        vecs.push_back(mk(0, 0, 32'h04, 32'h0, 0, 0, 32'h1234_5678, 0, 1, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0C, 32'hCAFE_0001, 3, 3, 32'h0, 0, 4, 32'hCAFE_0001));
        vecs.push_back(mk(0, 0, 32'h0C, 32'h0, 16, 16, 32'hCAFE_0001, 0, 17, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0C, 32'h0, 17, 17, 32'h0, 1, 17, 32'h0));
        vecs.push_back(mk(0, 0, 32'h10, 32'h0, 1, 1, 32'h0, 1, 17, 32'h0));
        vecs.push_back(mk(1, 0, 32'h09, 32'h0000_0055, 2, 2, 32'h0, 0, 3, 32'h0000_0055));
        vecs.push_back(mk(0, 0, 32'h0B, 32'h0, 2, 2, 32'h0000_0055, 0, 3, 32'h0));
`ifdef CELLRV32_BUS_INIT_RMW_EN
        vecs.push_back(mk(1, 0, 32'h08, 32'h0000_00F0, 1, 1, 32'h0, 0, 2, 32'h0000_00F0));
        vecs.push_back(mk(1, 1, 32'h08, 32'h0000_000F, 1, 1, 32'h0000_00F0, 0, 5, 32'h0000_00FF));
        vecs.push_back(mk(1, 2, 32'h08, 32'h0000_0030, 1, 1, 32'h0000_00FF, 0, 5, 32'h0000_00CF));
        vecs.push_back(mk(1, 3, 32'h08, 32'h0000_000F, 1, 1, 32'h0000_00CF, 0, 5, 32'h0000_00C0));
        vecs.push_back(mk(0, 0, 32'h08, 32'h0, 1, 1, 32'h0000_00C0, 0, 2, 32'h0));
        vecs.push_back(mk(1, 3, 32'h04, 32'hFFFF_0000, 0, 0, 32'h1234_5678, 0, 3, 32'hEDCB_5678));
        vecs.push_back(mk(1, 1, 32'h08, 32'h0000_0001, 1, 17, 32'h0000_00C0, 1, 20, 32'h0000_00C1));
        vecs.push_back(mk(1, 1, 32'h0C, 32'h0000_0001, 17, 1, 32'h0, 1, 17, 32'h0));
        vecs.push_back(mk(1, 2, 32'h10, 32'h0000_0001, 1, 1, 32'h0, 1, 17, 32'h0));
`else
        vecs.push_back(mk(1, 1, 32'h04, 32'h0000_000F, 1, 1, 32'h0, 0, 2, 32'h0000_000F));
        vecs.push_back(mk(0, 0, 32'h04, 32'h0, 1, 1, 32'h0000_000F, 0, 2, 32'h0));
`endif

        // Reset values, sampled while reset is held and again after release.
        repeat (3) @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'h0);
        chk("rst.strobes", {30'h0, bus_rden, bus_wren}, 32'h0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk("rst.bus_data", bus_dout, 32'h0);
        rst = 1'b0;

        // Spurious ack while idle must not produce a response.
        spur_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("spur.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("spur.req_ready", 32'(req_ready), 32'd1);
        end
        spur_ack = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            if (i == 0) chk("vec0.gpio_o", {24'h0, dev_mem[2][7:0]}, 32'h0000_00FF);
        end

        // Backpressure: response held 6 cycles, late ack arrives meanwhile, new request waits.
        lat_rd = 20;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_op = 2'b00; req_addr = 32'h08; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = 32'h00;
        n = 0;
        while (!rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("bp.edges", 32'(n), 32'd17);
        for (int k = 0; k < 6; k++) begin
            chk("bp.valid", 32'(rsp_valid), 32'd1);
            chk("bp.rdata", rsp_rdata, 32'h0);
            chk("bp.err", 32'(rsp_err), 32'd1);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        lat_rd = 1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.consumed", 32'(rsp_valid), 32'd0);
        chk("bp.not_yet", 32'(bus_rden), 32'd0);
        chk("bp.ready_again", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp.next_rden", 32'(bus_rden), 32'd1);
        chk("bp.next_addr", bus_addr, 32'h0);
        n = 0;
        while (!rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
        chk("bp.next_rdata", rsp_rdata, GPIO_IN);
        chk("bp.next_edges", 32'(n), 32'd2);
        repeat (3) @(posedge clk);

        // Async reset during ACCESS (d=0) and WAIT (d=1): strobes drop, no response.
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; rsp_ready = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (d != 0) begin repeat (3) @(posedge clk); #1; end
            chk("arst.pre_rden", 32'(bus_rden), 32'(d == 0));
            #2 rst = 1'b1;
            #1;
            chk("arst.strobes", {30'h0, bus_rden, bus_wren}, 32'h0);
            chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("arst.req_ready", 32'(req_ready), 32'd1);
            @(negedge clk) rst = 1'b0;
            seen = 0;
            repeat (25) begin @(negedge clk); if (rsp_valid) seen++; end
            chk("arst.no_rsp", 32'(seen), 32'd0);
            chk("arst.idle_ready", 32'(req_ready), 32'd1);
        end

        // Randomized run against a word-level memory model.
        model_mem[0] = GPIO_IN;
        for (int w = 1; w < 4; w++) begin
            model_mem[w] = $urandom;
            run_txn(mk(1, 0, 32'(w * 4), model_mem[w], 1, 1, 32'h0, 0, 2, model_mem[w]),
                    $sformatf("init%0d", w));
        end
        for (int t = 0; t < 100; t++) begin
            rv.we = 1'($urandom_range(0, 1));
            rv.op = 2'($urandom_range(0, 3));
            idx = 3'($urandom_range(0, 5));
            rv.addr = {27'h0, idx, 2'($urandom_range(0, 3))};
            rv.wdata = $urandom;
            lat = pool[$urandom_range(0, 5)];
            if (rv.we && !is_rmw(rv.we, rv.op) && lat > TMO) lat = 2;
            rv.lrd = lat; rv.lwr = lat;
            rv.exp_wd = 32'h0;
            if (idx > 3'd3 || lat > TMO) begin
                rv.exp_rd = 32'h0; rv.exp_err = 1'b1; rv.exp_edges = TMO + 1;
                if (rv.we && !is_rmw(rv.we, rv.op)) rv.exp_wd = rv.wdata;
            end else begin
                old_v = model_mem[idx];
                rv.exp_err = 1'b0;
                if (is_rmw(rv.we, rv.op)) begin
                    case (rv.op)
                        2'b01:   new_v = old_v | rv.wdata;
                        2'b10:   new_v = old_v & ~rv.wdata;
                        default: new_v = old_v ^ rv.wdata;
                    endcase
                    rv.exp_rd = old_v; rv.exp_wd = new_v; rv.exp_edges = 2 * lat + 3;
                    if (idx != 3'd0) model_mem[idx] = new_v;
                end else if (rv.we) begin
                    rv.exp_rd = 32'h0; rv.exp_wd = rv.wdata; rv.exp_edges = lat + 1;
                    if (idx != 3'd0) model_mem[idx] = rv.wdata;
                end else begin
                    rv.exp_rd = old_v; rv.exp_edges = lat + 1;
                end
            end
            run_txn(rv, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
